// File: rtl/instr_register_mc.sv
// Instruction register stack with write-time result computation.
// Simple ops complete at the accepting edge; DIV/MOD run an iterative
// restoring divider on operand magnitudes and write back after OP_W+1 cycles.
// Reads are registered, never stalled, and flag unwritten/out-of-range entries.
module instr_register_mc #(
   parameter int OP_W  = 32,
   parameter int DEPTH = 32,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                load_en,
   output logic                load_ready,
   input  logic [AW-1:0]       write_pointer,
   input  logic [2:0]          opcode,
   input  logic [OP_W-1:0]     operand_a,
   input  logic [OP_W-1:0]     operand_b,
   input  logic                read_en,
   input  logic [AW-1:0]       read_pointer,
   output logic                rd_valid,
   output logic                rd_err,
   output logic [2:0]          rd_opc,
   output logic [OP_W-1:0]     rd_op_a,
   output logic [OP_W-1:0]     rd_op_b,
   output logic [2*OP_W-1:0]   rd_result
);

   // state    | meaning
   // ---------+-----------------------------------------------------------
   // S_IDLE   | accepting writes; simple ops written immediately
   // S_DIVIDE | one quotient bit per cycle for OP_W cycles, writer stalled
   // S_WRITE  | sign fix applied, divide result written, writer stalled

   localparam int RW = 2 * OP_W;
   localparam int CW = $clog2(OP_W + 1);

   localparam logic [2:0] OPC_ZERO  = 3'd0;
   localparam logic [2:0] OPC_PASSA = 3'd1;
   localparam logic [2:0] OPC_PASSB = 3'd2;
   localparam logic [2:0] OPC_ADD   = 3'd3;
   localparam logic [2:0] OPC_SUB   = 3'd4;
   localparam logic [2:0] OPC_MULT  = 3'd5;
   localparam logic [2:0] OPC_DIV   = 3'd6;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_DIVIDE = 2'd1;
   localparam logic [1:0] S_WRITE  = 2'd2;

   logic [2:0]      opc_q   [DEPTH];
   logic [OP_W-1:0] a_q     [DEPTH];
   logic [OP_W-1:0] b_q     [DEPTH];
   logic [RW-1:0]   res_q   [DEPTH];
   logic            valid_q [DEPTH];

   logic [1:0]      state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [OP_W-1:0] rem_q, rem_d;
   logic [OP_W-1:0] quo_q, quo_d;
   logic [OP_W-1:0] dsr_q, dsr_d;
   logic [2:0]      cap_opc_q, cap_opc_d;
   logic [OP_W-1:0] cap_a_q, cap_a_d;
   logic [OP_W-1:0] cap_b_q, cap_b_d;
   logic [AW-1:0]   cap_ptr_q, cap_ptr_d;

   logic            rd_valid_q, rd_err_q;
   logic [2:0]      rd_opc_q;
   logic [OP_W-1:0] rd_op_a_q, rd_op_b_q;
   logic [RW-1:0]   rd_result_q;

   logic            accept, is_div, wr_in_range, rd_in_range;
   logic [RW-1:0]   simple_res, div_res;
   logic [OP_W:0]   trial;
   logic [OP_W-1:0] diff;
   logic            ge;

   logic            we;
   logic [AW-1:0]   w_ptr;
   logic [2:0]      w_opc;
   logic [OP_W-1:0] w_a, w_b;
   logic [RW-1:0]   w_res;

   assign load_ready  = (state_q == S_IDLE);
   assign accept      = load_en && load_ready;
   assign is_div      = opcode[2] & opcode[1];
   assign wr_in_range = {1'b0, write_pointer} < (AW+1)'(DEPTH);
   assign rd_in_range = {1'b0, read_pointer} < (AW+1)'(DEPTH);

   // Single-cycle ALU on sign-extended operands; widths make overflow impossible
   always_comb begin
      logic [RW-1:0] ax, bx;
      ax = {{OP_W{operand_a[OP_W-1]}}, operand_a};
      bx = {{OP_W{operand_b[OP_W-1]}}, operand_b};
      simple_res = '0;
      case (opcode)
         OPC_ZERO:  simple_res = '0;
         OPC_PASSA: simple_res = ax;
         OPC_PASSB: simple_res = bx;
         OPC_ADD:   simple_res = ax + bx;
         OPC_SUB:   simple_res = ax - bx;
         OPC_MULT:  simple_res = ax * bx;
         default:   simple_res = '0;
      endcase
   end

   // One restoring-division step: shift in next dividend bit, subtract if it fits
   always_comb begin
      trial = {rem_q, quo_q[OP_W-1]};
      ge    = trial >= {1'b0, dsr_q};
      diff  = trial[OP_W-1:0] - dsr_q;
   end

   // Sign fix: quotient negative when signs differ, remainder follows dividend
   always_comb begin
      logic [RW-1:0] q_ext, r_ext;
      q_ext   = {{OP_W{1'b0}}, quo_q};
      r_ext   = {{OP_W{1'b0}}, rem_q};
      div_res = '0;
      if (cap_b_q != '0) begin
         if (cap_opc_q == OPC_DIV)
            div_res = (cap_a_q[OP_W-1] ^ cap_b_q[OP_W-1]) ? (RW'(0) - q_ext) : q_ext;
         else
            div_res = cap_a_q[OP_W-1] ? (RW'(0) - r_ext) : r_ext;
      end
   end

   // FSM and divider next-state; zero divisor runs the full path for fixed latency
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dsr_d     = dsr_q;
      cap_opc_d = cap_opc_q;
      cap_a_d   = cap_a_q;
      cap_b_d   = cap_b_q;
      cap_ptr_d = cap_ptr_q;
      case (state_q)
         S_IDLE: begin
            if (accept && wr_in_range && is_div) begin
               state_d   = S_DIVIDE;
               cnt_d     = CW'(OP_W - 1);
               rem_d     = '0;
               quo_d     = operand_a[OP_W-1] ? (OP_W'(0) - operand_a) : operand_a;
               dsr_d     = operand_b[OP_W-1] ? (OP_W'(0) - operand_b) : operand_b;
               cap_opc_d = opcode;
               cap_a_d   = operand_a;
               cap_b_d   = operand_b;
               cap_ptr_d = write_pointer;
            end
         end
         S_DIVIDE: begin
            rem_d = ge ? diff : trial[OP_W-1:0];
            quo_d = {quo_q[OP_W-2:0], ge};
            if (cnt_q == '0)
               state_d = S_WRITE;
            else
               cnt_d = cnt_q - 1'b1;
         end
         S_WRITE:  state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Write port select: immediate simple op, or finished divide
   always_comb begin
      we    = 1'b0;
      w_ptr = write_pointer;
      w_opc = opcode;
      w_a   = operand_a;
      w_b   = operand_b;
      w_res = simple_res;
      if (state_q == S_IDLE && accept && wr_in_range && !is_div) begin
         we = 1'b1;
      end else if (state_q == S_WRITE) begin
         we    = 1'b1;
         w_ptr = cap_ptr_q;
         w_opc = cap_opc_q;
         w_a   = cap_a_q;
         w_b   = cap_b_q;
         w_res = div_res;
      end
   end

   // FSM and divider registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dsr_q     <= '0;
         cap_opc_q <= '0;
         cap_a_q   <= '0;
         cap_b_q   <= '0;
         cap_ptr_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dsr_q     <= dsr_d;
         cap_opc_q <= cap_opc_d;
         cap_a_q   <= cap_a_d;
         cap_b_q   <= cap_b_d;
         cap_ptr_q <= cap_ptr_d;
      end
   end

   // Entry storage; a write overwrites every field and marks the entry valid
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            opc_q[i]   <= '0;
            a_q[i]     <= '0;
            b_q[i]     <= '0;
            res_q[i]   <= '0;
            valid_q[i] <= 1'b0;
         end
      end else if (we) begin
         opc_q[w_ptr]   <= w_opc;
         a_q[w_ptr]     <= w_a;
         b_q[w_ptr]     <= w_b;
         res_q[w_ptr]   <= w_res;
         valid_q[w_ptr] <= 1'b1;
      end
   end

   // Registered read port; samples pre-write contents, data zeroed on error
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rd_valid_q  <= 1'b0;
         rd_err_q    <= 1'b0;
         rd_opc_q    <= '0;
         rd_op_a_q   <= '0;
         rd_op_b_q   <= '0;
         rd_result_q <= '0;
      end else begin
         rd_valid_q <= read_en;
         if (read_en) begin
            if (rd_in_range && valid_q[read_pointer]) begin
               rd_err_q    <= 1'b0;
               rd_opc_q    <= opc_q[read_pointer];
               rd_op_a_q   <= a_q[read_pointer];
               rd_op_b_q   <= b_q[read_pointer];
               rd_result_q <= res_q[read_pointer];
            end else begin
               rd_err_q    <= 1'b1;
               rd_opc_q    <= '0;
               rd_op_a_q   <= '0;
               rd_op_b_q   <= '0;
               rd_result_q <= '0;
            end
         end
      end
   end

   assign rd_valid  = rd_valid_q;
   assign rd_err    = rd_err_q;
   assign rd_opc    = rd_opc_q;
   assign rd_op_a   = rd_op_a_q;
   assign rd_op_b   = rd_op_b_q;
   assign rd_result = rd_result_q;

endmodule
